// File: rtl/mac_operand_feeder.sv
// Operand staging for the MAC accumulator: two show-ahead FIFOs feed one A/B pair
// per cycle, with clear/enable timed around the MAC's registered multiplier.
module mac_operand_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_wr_en,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic                  b_wr_en,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    input  logic                  start,
    output logic                  a_full,
    output logic                  b_full,
    output logic                  a_empty,
    output logic                  b_empty,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] mac_ain,
    output logic [DATA_WIDTH-1:0] mac_bin,
    output logic                  mac_en,
    output logic                  mac_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_NEED = CW'(VEC_LEN);
    localparam logic [KW-1:0] K_LAST   = KW'(VEC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            pop;

    logic [1:0]            push;
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] head  [2];
    logic [CW-1:0]         count [2];
    logic [1:0]            full;
    logic [1:0]            empty;

    assign push     = {b_wr_en, a_wr_en};
    assign wdata[0] = a_wr_data;
    assign wdata[1] = b_wr_data;
    assign pop      = (state == FEED);

    // Index 0 is the A FIFO, index 1 the B FIFO; both pop together during FEED.
    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         rd_ptr;
        logic [PW-1:0]         wr_ptr;
        logic [CW-1:0]         cnt;
        logic                  do_push;
        logic                  do_pop;

        assign do_pop  = pop && (cnt != '0);
        // A pop in the same cycle frees the slot, so a push into a full FIFO can still land.
        assign do_push = push[f] && ((cnt != CNT_FULL) || do_pop);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (do_push) begin
                mem[wr_ptr] <= wdata[f];
            end
        end

        assign head[f]  = mem[rd_ptr];
        assign count[f] = cnt;
        assign full[f]  = (cnt == CNT_FULL);
        assign empty[f] = (cnt == '0);
    end

    assign a_full  = full[0];
    assign b_full  = full[1];
    assign a_empty = empty[0];
    assign b_empty = empty[1];

    // Operands are forced to zero outside FEED so the MAC multiplier sees no stale data.
    assign mac_ain = pop ? head[0] : '0;
    assign mac_bin = pop ? head[1] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
        end else begin
            // Enable trails the pop by one cycle to match the MAC's product register.
            mac_en  <= pop;
            mac_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (count[0] >= CNT_NEED) && (count[1] >= CNT_NEED)) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    k     <= '0;
                    state <= FEED;
                end
                FEED: begin
                    k <= k + KW'(1);
                    if (k == K_LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural MAC downstream.
module tb_mac_operand_feeder;

    localparam int DW = 8;
    localparam int VL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_wr_en = 1'b0;
    logic [DW-1:0] a_wr_data = '0;
    logic          b_wr_en = 1'b0;
    logic [DW-1:0] b_wr_data = '0;
    logic          start = 1'b0;
    logic          a_full, b_full, a_empty, b_empty;
    logic          busy, done, mac_en, mac_clr;
    logic [DW-1:0] mac_ain, mac_bin;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];

    // MAC: registered multiplier feeding a 3*DW accumulator
    logic [2*DW-1:0] prod;
    logic [3*DW-1:0] cout;

    always #5 clk = ~clk;

    mac_operand_feeder #(.DATA_WIDTH(DW), .DEPTH(8), .VEC_LEN(VL)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_wr_en(a_wr_en), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_data(b_wr_data),
        .start(start),
        .a_full(a_full), .b_full(b_full), .a_empty(a_empty), .b_empty(b_empty),
        .busy(busy), .done(done),
        .mac_ain(mac_ain), .mac_bin(mac_bin), .mac_en(mac_en), .mac_clr(mac_clr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
            cout <= '0;
        end else begin
            prod <= mac_ain * mac_bin;
            if (mac_clr) cout <= '0;
            else if (mac_en) cout <= cout + {{DW{1'b0}}, prod};
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input bit ea, input int da, input bit eb, input int db);
        @(negedge clk);
        start = 1'b0;
        a_wr_en = ea; a_wr_data = DW'(da);
        b_wr_en = eb; b_wr_data = DW'(db);
        if (ea && exp_a.size() < 8) exp_a.push_back(DW'(da));
        if (eb && exp_b.size() < 8) exp_b.push_back(DW'(db));
    endtask

    task automatic idle();
        @(negedge clk);
        a_wr_en = 1'b0; b_wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic run(input string tag, input int exp_sum, input bit push_feed,
                       input int pa, input int pb);
        @(negedge clk);
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " clr"}, int'(mac_clr), 1);
        chk({tag, " busy1"}, int'(busy), 1);
        chk({tag, " en1"}, int'(mac_en), 0);
        for (int c = 2; c <= VL + 3; c++) begin
            @(negedge clk);
            a_wr_en = 1'b0; b_wr_en = 1'b0;
            chk($sformatf("%s en c%0d", tag, c), int'(mac_en), int'(c >= 3 && c <= VL + 2));
            chk($sformatf("%s clr c%0d", tag, c), int'(mac_clr), 0);
            chk($sformatf("%s done c%0d", tag, c), int'(done), int'(c == VL + 3));
            if (c <= VL + 1) begin
                chk($sformatf("%s ain c%0d", tag, c), int'(mac_ain), int'(exp_a.pop_front()));
                chk($sformatf("%s bin c%0d", tag, c), int'(mac_bin), int'(exp_b.pop_front()));
                if (push_feed) begin
                    a_wr_en = 1'b1; a_wr_data = DW'(pa);
                    b_wr_en = 1'b1; b_wr_data = DW'(pb);
                    exp_a.push_back(DW'(pa));
                    exp_b.push_back(DW'(pb));
                end
            end else begin
                chk($sformatf("%s ain0 c%0d", tag, c), int'(mac_ain), 0);
            end
        end
        chk({tag, " busy done"}, int'(busy), 1);
        chk({tag, " cout"}, int'(cout), exp_sum);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst en", int'(mac_en), 0);
        chk("rst clr", int'(mac_clr), 0);
        chk("rst ain", int'(mac_ain), 0);
        chk("rst a_empty", int'(a_empty), 1);
        chk("rst b_empty", int'(b_empty), 1);
        chk("rst a_full", int'(a_full), 0);
        rst_n = 1'b1;

        // Basic dot product: A=1..8, B=2 -> 72
        for (int i = 1; i <= 8; i++) push(1, i, 1, 2);
        idle();
        chk("basic a_full", int'(a_full), 1);
        chk("basic b_full", int'(b_full), 1);
        run("basic", 72, 0, 0, 0);
        chk("basic a_empty", int'(a_empty), 1);
        chk("basic b_empty", int'(b_empty), 1);
        idle();
        chk("basic idle busy", int'(busy), 0);

        // Max values: 8*255*255 = 520200
        for (int i = 0; i < 8; i++) push(1, 255, 1, 255);
        run("max", 520200, 0, 0, 0);

        // Insufficient data: 7 A entries, start ignored
        for (int i = 1; i <= 7; i++) push(1, i, 1, 1);
        push(0, 0, 1, 1);
        idle();
        start = 1'b1;
        idle();
        chk("short busy", int'(busy), 0);
        chk("short clr", int'(mac_clr), 0);
        idle();
        chk("short busy2", int'(busy), 0);
        push(1, 8, 0, 0);
        run("short", 36, 0, 0, 0);

        // Overflow: 9 pushes into A, the 9th (18) dropped; sum 10..17 = 108
        for (int i = 10; i <= 17; i++) push(1, i, 1, 1);
        idle();
        chk("ovf a_full", int'(a_full), 1);
        push(1, 18, 0, 0);
        idle();
        chk("ovf a_full2", int'(a_full), 1);
        run("ovf", 108, 0, 0, 0);
        idle();
        chk("ovf a_empty", int'(a_empty), 1);
        // Second run with wrapped pointers: sum i*(9-i) = 120
        for (int i = 1; i <= 8; i++) push(1, i, 1, 9 - i);
        run("wrap", 120, 0, 0, 0);

        // Push during FEED, then back-to-back start: 36 then 8*3*4 = 96
        for (int i = 1; i <= 8; i++) push(1, i, 1, 1);
        run("feedpush", 36, 1, 3, 4);
        chk("feedpush a_full", int'(a_full), 1);
        chk("feedpush b_full", int'(b_full), 1);
        run("b2b", 96, 0, 0, 0);

        // Reset in the 4th FEED cycle
        for (int i = 1; i <= 8; i++) push(1, i, 1, 1);
        idle();
        start = 1'b1;
        idle();
        repeat (4) @(negedge clk);
        chk("pre-rst ain", int'(mac_ain), 4);
        rst_n = 1'b0;
        #1;
        chk("mid busy", int'(busy), 0);
        chk("mid en", int'(mac_en), 0);
        chk("mid ain", int'(mac_ain), 0);
        chk("mid bin", int'(mac_bin), 0);
        chk("mid clr", int'(mac_clr), 0);
        chk("mid done", int'(done), 0);
        chk("mid a_empty", int'(a_empty), 1);
        chk("mid b_empty", int'(b_empty), 1);
        chk("mid a_full", int'(a_full), 0);
        exp_a.delete();
        exp_b.delete();
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(1, 5, 1, 6);
        run("postrst", 240, 0, 0, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
